// File: rtl/alu_pkg.sv
// Shared op-code and FSM encodings for the sequential ALU.
// Imported by alu_seq and alu_mul_iter.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_NAND = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle.
// done is high during the final step; result is the accumulator after that step.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    assign result = acc + (mplier[0] ? mcand : '0);
    assign done   = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= result;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; single-cycle ops inline,
// MUL delegated to an iterative shift-add unit.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             co,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    state_t state;
    state_t state_nx;

    logic             accept;
    logic             is_mul;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;

    logic             sub;
    logic [WIDTH-1:0] b_add;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_co;
    logic             alu_ovf;
    logic             alu_ill;

    assign is_mul = (op == OP_MUL);
    assign accept = in_valid && in_ready;
    assign shamt  = b[SHW-1:0];

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && is_mul),
        .a      (a),
        .b      (b),
        .busy   (mul_busy),
        .done   (mul_done),
        .result (mul_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = is_mul ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_nx = is_mul ? ST_MUL : ST_DONE;
                end else if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
        out_valid = (state == ST_DONE);
    end

    // SUB/SLT/SLTU share the adder as A + ~B + 1
    always_comb begin
        sub          = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
        b_add        = sub ? ~b : b;
        {carry, sum} = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, sub};
        ovf          = (a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        alu_res      = '0;
        alu_co       = 1'b0;
        alu_ovf      = 1'b0;
        alu_ill      = 1'b0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_NAND: alu_res = ~(a & b);
            OP_XOR:  alu_res = a ^ b;
            OP_ADD, OP_SUB: begin
                alu_res = sum;
                alu_co  = carry;
                alu_ovf = ovf;
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~carry};
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_MUL:  alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res      <= '0;
            co       <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else if (accept && !is_mul) begin
            res      <= alu_res;
            co       <= alu_co;
            zero     <= (alu_res == '0);
            overflow <= alu_ovf;
            illegal  <= alu_ill;
        end else if (state == ST_MUL && mul_busy && mul_done) begin
            res      <= mul_res;
            co       <= 1'b0;
            zero     <= (mul_res == '0);
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal range 4..64.
REQ-002 SHALL have localparam SHW = $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, operand/op presented.
REQ-006 SHALL have port in_ready, output, 1, block accepts this cycle.
REQ-007 SHALL have port a, input, WIDTH, operand A.
REQ-008 SHALL have port b, input, WIDTH, operand B; b[SHW-1:0] is the shift amount for shifts.
REQ-009 SHALL have port op, input, 4, operation code (REQ-016).
REQ-010 SHALL have port out_valid, output, 1, result held.
REQ-011 SHALL have port out_ready, input, 1, consumer takes result.
REQ-012 SHALL have port res, output, WIDTH, result.
REQ-013 SHALL have ports co, zero, overflow, illegal, output, 1 each, registered flags.

Function
REQ-014 SHALL accept a transaction on a rising edge where in_valid && in_ready; a, b, op are captured on that edge.
REQ-015 SHALL run an FSM with states IDLE, MUL, DONE: IDLE->DONE on accept of single-cycle op; IDLE->MUL on accept of MUL; MUL->DONE after WIDTH cycles in MUL; DONE->IDLE on out_ready with no new accept; DONE->DONE/MUL on out_ready with a simultaneous accept.
REQ-016 SHALL decode op: 0 AND, 1 OR, 2 ADD, 3 NOR, 4 NAND, 5 XOR, 6 SUB, 7 SLT (signed), 8 SLTU, 9 SLL, 10 SRL, 11 SRA, 12 MUL (low WIDTH bits of product); 13..15 reserved.
REQ-017 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-018 SHALL assert out_valid only in DONE; res and flags SHALL stay stable while out_valid && !out_ready.
REQ-019 SHALL give latency 1 (out_valid high the cycle after accept) for all ops except MUL, which SHALL give latency WIDTH+1.
REQ-020 SHALL compute MUL iteratively, one multiplier bit per cycle, shift-add, using one WIDTH-bit adder shared with ADD/SUB or a dedicated one; no combinational multiplier.
REQ-021 SHALL compute SUB and SLT/SLTU via A + ~B + 1; SLT = sign(A-B) xor overflow; SLTU = !carry; result zero-extended 0/1.
REQ-022 SHALL set co = adder carry-out for ADD/SUB (SUB: 1 = no borrow), else 0.
REQ-023 SHALL set overflow = signed two's-complement overflow for ADD/SUB, else 0.
REQ-024 SHALL set zero = (res == 0) for every op, including reserved.
REQ-025 SHALL use only b[SHW-1:0] as shift amount; upper bits of b ignored; SRA replicates a[WIDTH-1].
REQ-026 SHALL for reserved op produce res 0, zero 1, illegal 1, latency 1; illegal SHALL be 0 for all legal ops.

Reset
REQ-027 SHALL on rst_n low at a rising edge force state IDLE, out_valid 0, res 0, co 0, zero 0, overflow 0, illegal 0, MUL counter 0; in_ready SHALL be 1 the cycle after.
REQ-028 SHALL abort an in-flight MUL on reset with no result delivered; rst_n low overrides a simultaneous accept.

Structure
REQ-029 SHALL place op-code localparams (OP_AND..OP_MUL) and FSM state encodings in shared package alu_pkg.
REQ-030 SHALL contain one sub-module, alu_mul_iter (shift-add multiplier with start/busy/done), instantiated once; all other ops inline.

Verification
REQ-031 SHALL cover: WIDTH=32, ADD a=0x7FFFFFFF b=1 -> res 0x80000000, overflow 1, co 0, zero 0, out_valid 1 cycle after accept.
REQ-032 SHALL cover: SUB 5-5 -> res 0, zero 1, co 1; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0.
REQ-033 SHALL cover: SRA a=0x80000000 b=36 -> 0xF8000000 (shift 4); SRL same -> 0x08000000; op=14 -> res 0, illegal 1.
REQ-034 SHALL cover: MUL 0x00010000 x 0x00010000 -> res 0, zero 1, out_valid exactly 33 cycles after accept, in_ready 0 throughout MUL.
REQ-035 SHALL cover: out_ready held low 3 cycles in DONE -> res/flags unchanged; then out_ready 1 with in_valid 1 -> back-to-back accept, next result 1 cycle later.
REQ-036 SHALL cover: rst_n low on 10th MUL cycle -> next cycle state IDLE, out_valid 0, in_ready 1, no stale result emitted.
